// File: rtl/uart_pkg.sv
// uart_pkg: shared oversampling constants, receiver FSM state type and vote helper.
package uart_pkg;
   localparam int OVERSAMPLE = 16;
   localparam logic [3:0] SAMPLE_A = 4'd7;
   localparam logic [3:0] SAMPLE_B = 4'd8;
   localparam logic [3:0] SAMPLE_C = 4'd9;
   localparam logic [3:0] BIT_END = 4'd15;
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} rx_state_e;
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
endpackage

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: line, configuration and holding-register signals of the UART receiver.
interface uart_rx_frame_if;
   logic baud_clock, bit8, parity_en, odd_n_even, rx, read_rx_byte;
   logic [7:0] rx_byte;
   logic rx_data_ready, parity_err, framing_err, overflow, rx_idle;
   modport master (
      output baud_clock, bit8, parity_en, odd_n_even, rx, read_rx_byte,
      input  rx_byte, rx_data_ready, parity_err, framing_err, overflow, rx_idle
   );
   modport slave (
      input  baud_clock, bit8, parity_en, odd_n_even, rx, read_rx_byte,
      output rx_byte, rx_data_ready, parity_err, framing_err, overflow, rx_idle
   );
endinterface

// File: rtl/uart_rx_bit_sampler.sv
// uart_rx_bit_sampler: synchronises rx, counts 16x ticks per bit and majority-votes
// ticks 7/8/9 into one bit decision.
module uart_rx_bit_sampler
   import uart_pkg::*;
#(
   parameter int   SYNC_STAGES   = 2,
   parameter logic RX_IDLE_LEVEL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic baud_clock,
   input  logic rx,
   input  logic run,
   output logic rx_s,
   output logic bit_val,
   output logic bit_decide,
   output logic bit_end
);
   localparam int CW = $clog2(OVERSAMPLE);
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0] samp_cnt_q, samp_cnt_d;
   logic samp_a_q, samp_a_d, samp_b_q, samp_b_d;
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], rx};
      samp_cnt_d = baud_clock ? (run ? samp_cnt_q + 1'b1 : '0) : samp_cnt_q;
      samp_a_d = (baud_clock && samp_cnt_q == SAMPLE_A) ? rx_s : samp_a_q;
      samp_b_d = (baud_clock && samp_cnt_q == SAMPLE_B) ? rx_s : samp_b_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{RX_IDLE_LEVEL}};
         samp_cnt_q <= '0;
         samp_a_q <= 1'b0;
         samp_b_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         samp_cnt_q <= samp_cnt_d;
         samp_a_q <= samp_a_d;
         samp_b_q <= samp_b_d;
      end
   end
   assign rx_s = sync_q[SYNC_STAGES-1];
   assign bit_val = majority3(samp_a_q, samp_b_q, rx_s);
   assign bit_decide = baud_clock && samp_cnt_q == SAMPLE_C;
   assign bit_end = baud_clock && samp_cnt_q == BIT_END;
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receive FSM, shift register, parity check and one-entry
// holding register with ready/error/overflow status.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int   SYNC_STAGES   = 2,
   parameter logic RX_IDLE_LEVEL = 1'b1
) (
   input logic            clk,
   input logic            reset,
   uart_rx_frame_if.slave bus
);
   rx_state_e state_q, state_d;
   logic armed_q, armed_d, p_err_q, p_err_d;
   logic bit8_q, bit8_d, par_en_q, par_en_d, odd_q, odd_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] shreg_q, shreg_d, data_w;
   logic load_q, load_d, ld_pe_q, ld_pe_d, ld_fe_q, ld_fe_d;
   logic [7:0] ld_byte_q, ld_byte_d, rx_byte_q, rx_byte_d;
   logic rdy_q, rdy_d, pe_q, pe_d, fe_q, fe_d, ovf_q, ovf_d;
   logic rx_s, bit_val, bit_decide, bit_end, rd, take;

   uart_rx_bit_sampler #(.SYNC_STAGES(SYNC_STAGES), .RX_IDLE_LEVEL(RX_IDLE_LEVEL)) u_sampler (
      .clk(clk), .reset(reset), .baud_clock(bus.baud_clock), .rx(bus.rx),
      .run(state_d != ST_IDLE), .rx_s(rx_s), .bit_val(bit_val),
      .bit_decide(bit_decide), .bit_end(bit_end)
   );

   // 7-bit frames sit in the top seven shift bits after the last shift
   assign data_w = bit8_q ? shreg_q : {1'b0, shreg_q[7:1]};

   always_comb begin
      state_d = state_q;
      armed_d = armed_q;
      idx_d = idx_q;
      shreg_d = shreg_q;
      p_err_d = p_err_q;
      bit8_d = bit8_q;
      par_en_d = par_en_q;
      odd_d = odd_q;
      load_d = 1'b0;
      ld_byte_d = ld_byte_q;
      ld_pe_d = ld_pe_q;
      ld_fe_d = ld_fe_q;
      case (state_q)
         ST_IDLE: if (bus.baud_clock) begin
            armed_d = armed_q | rx_s;
            if (armed_q && !rx_s) begin
               state_d = ST_START;
               armed_d = 1'b0;
               p_err_d = 1'b0;
               bit8_d = bus.bit8;
               par_en_d = bus.parity_en;
               odd_d = bus.odd_n_even;
            end
         end
         ST_START: begin
            if (bit_decide && bit_val) begin
               state_d = ST_IDLE;
               armed_d = 1'b1;
            end else if (bit_end) begin
               state_d = ST_DATA;
               idx_d = 3'd0;
            end
         end
         ST_DATA: begin
            if (bit_decide) shreg_d = {bit_val, shreg_q[7:1]};
            if (bit_end) begin
               idx_d = idx_q + 3'd1;
               if (idx_q == (bit8_q ? 3'd7 : 3'd6)) state_d = par_en_q ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (bit_decide) p_err_d = bit_val ^ (^data_w) ^ odd_q;
            if (bit_end) state_d = ST_STOP;
         end
         ST_STOP: if (bit_decide) begin
            state_d = ST_IDLE;
            armed_d = bit_val;
            load_d = 1'b1;
            ld_byte_d = data_w;
            ld_pe_d = p_err_q;
            ld_fe_d = ~bit_val;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // a load only replaces the held byte if it is free or being read this clk
   always_comb begin
      rd = bus.read_rx_byte & rdy_q;
      take = load_q & (~rdy_q | rd);
      rdy_d = take | (rdy_q & ~rd);
      ovf_d = (load_q & ~take) | (ovf_q & ~rd);
      rx_byte_d = take ? ld_byte_q : rx_byte_q;
      pe_d = take ? ld_pe_q : pe_q;
      fe_d = take ? ld_fe_q : fe_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         armed_q <= 1'b0;
         idx_q <= '0;
         shreg_q <= '0;
         p_err_q <= 1'b0;
         bit8_q <= 1'b0;
         par_en_q <= 1'b0;
         odd_q <= 1'b0;
         load_q <= 1'b0;
         ld_byte_q <= '0;
         ld_pe_q <= 1'b0;
         ld_fe_q <= 1'b0;
         rx_byte_q <= '0;
         rdy_q <= 1'b0;
         pe_q <= 1'b0;
         fe_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
         idx_q <= idx_d;
         shreg_q <= shreg_d;
         p_err_q <= p_err_d;
         bit8_q <= bit8_d;
         par_en_q <= par_en_d;
         odd_q <= odd_d;
         load_q <= load_d;
         ld_byte_q <= ld_byte_d;
         ld_pe_q <= ld_pe_d;
         ld_fe_q <= ld_fe_d;
         rx_byte_q <= rx_byte_d;
         rdy_q <= rdy_d;
         pe_q <= pe_d;
         fe_q <= fe_d;
         ovf_q <= ovf_d;
      end
   end

   assign bus.rx_byte = rx_byte_q;
   assign bus.rx_data_ready = rdy_q;
   assign bus.parity_err = pe_q;
   assign bus.framing_err = fe_q;
   assign bus.overflow = ovf_q;
   assign bus.rx_idle = state_q == ST_IDLE;
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: drives serial frames at 64 clks/bit and compares the holding
// register against a frame-level model of the receiver.
module tb_uart_rx_frame;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int unsigned cyc = 0;
   int vec = 0, fails = 0, first_rdy = -1;
   logic [7:0] m_byte = '0;
   logic m_rdy = 1'b0, m_pe = 1'b0, m_fe = 1'b0, m_ovf = 1'b0;

   uart_rx_frame_if bus();
   uart_rx_frame #(.SYNC_STAGES(2), .RX_IDLE_LEVEL(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) bus.baud_clock = (cyc[1:0] == 2'd3);

   function automatic logic [12:0] got();
      return {bus.rx_byte, bus.rx_data_ready, bus.parity_err, bus.framing_err, bus.overflow, bus.rx_idle};
   endfunction
   function automatic logic [12:0] want();
      return {m_byte, m_rdy, m_pe, m_fe, m_ovf, 1'b1};
   endfunction

   task automatic model_frame(input logic [7:0] d, input logic pe, input logic fe, input logic same_read);
      if (m_rdy && !same_read) m_ovf = 1'b1;
      else begin
         m_byte = d; m_pe = pe; m_fe = fe; m_rdy = 1'b1; m_ovf = 1'b0;
      end
   endtask

   task automatic do_read();
      @(negedge clk);
      bus.read_rx_byte = 1'b1;
      @(negedge clk);
      bus.read_rx_byte = 1'b0;
      if (m_rdy) begin m_rdy = 1'b0; m_ovf = 1'b0; end
   endtask

   task automatic align();
      do @(negedge clk); while (cyc[1:0] != 2'd3);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic b8, input logic pen, input logic odd,
                             input logic flip, input logic stop, input int glitch_bit = -1,
                             input int rd_at = -1, input int rst_at = -1);
      logic q[$];
      logic [7:0] dm;
      dm = b8 ? d : {1'b0, d[6:0]};
      q.push_back(1'b0);
      for (int i = 0; i < (b8 ? 8 : 7); i++) q.push_back(dm[i]);
      if (pen) q.push_back((^dm) ^ odd ^ flip);
      q.push_back(stop);
      align();
      bus.bit8 = b8; bus.parity_en = pen; bus.odd_n_even = odd;
      first_rdy = -1;
      for (int b = 0; b < q.size(); b++)
         for (int i = 0; i < 64; i++) begin
            if (b == 1 && i == 0) {bus.bit8, bus.parity_en, bus.odd_n_even} = 3'($urandom);
            bus.rx = (glitch_bit >= 0 && b == glitch_bit + 1 && i == 35) ? ~q[b] : q[b];
            bus.read_rx_byte = (b * 64 + i == rd_at);
            reset = (b * 64 + i == rst_at);
            if (bus.rx_data_ready && first_rdy < 0) first_rdy = b * 64 + i;
            @(negedge clk);
         end
      bus.rx = 1'b1; bus.read_rx_byte = 1'b0; reset = 1'b0;
      repeat (16) @(negedge clk);
      if (rst_at >= 0) {m_byte, m_rdy, m_pe, m_fe, m_ovf} = '0;
      else model_frame(dm, pen & flip, ~stop, rd_at >= 0);
   endtask

   task automatic test_reset();
      bus.rx = 1'b1; bus.read_rx_byte = 1'b0; bus.bit8 = 1'b1; bus.parity_en = 1'b0; bus.odd_n_even = 1'b0;
      reset = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      vec++; if (got() !== 13'h001) begin fails++; $display("FAIL reset: got %h want %h", got(), 13'h001); end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_nominal();
      send_frame(8'hA5, 1, 0, 0, 0, 1);
      vec++; if (got() !== want()) begin fails++; $display("FAIL nominal_8n1: got %h want %h", got(), want()); end
      vec++; if (first_rdy < 615 || first_rdy > 619) begin fails++; $display("FAIL latency: got %0d want 615..619", first_rdy); end
      do_read();
      vec++; if (got() !== want()) begin fails++; $display("FAIL nominal_read: got %h want %h", got(), want()); end
   endtask

   task automatic test_parity();
      send_frame(8'h55, 0, 1, 0, 0, 1);
      vec++; if (got() !== want()) begin fails++; $display("FAIL par_7e1_ok: got %h want %h", got(), want()); end
      do_read();
      send_frame(8'h55, 0, 1, 0, 1, 1);
      vec++; if (got() !== want()) begin fails++; $display("FAIL par_7e1_bad: got %h want %h", got(), want()); end
      do_read();
      send_frame(8'h00, 1, 1, 1, 0, 1);
      vec++; if (got() !== want()) begin fails++; $display("FAIL par_8o1: got %h want %h", got(), want()); end
      do_read();
   endtask

   task automatic test_glitch();
      do_read();
      align();
      bus.rx = 1'b0;
      repeat (20) @(negedge clk);
      bus.rx = 1'b1;
      repeat (60) @(negedge clk);
      vec++; if (bus.rx_idle !== 1'b1) begin fails++; $display("FAIL false_start_idle: got %b want 1", bus.rx_idle); end
      repeat (700) @(negedge clk);
      vec++; if (got() !== want()) begin fails++; $display("FAIL false_start: got %h want %h", got(), want()); end
      send_frame(8'h00, 1, 0, 0, 0, 1, 3);
      vec++; if (got() !== want()) begin fails++; $display("FAIL glitch: got %h want %h", got(), want()); end
      do_read();
   endtask

   task automatic test_framing();
      send_frame(8'h3C, 1, 0, 0, 0, 0);
      vec++; if (got() !== want()) begin fails++; $display("FAIL framing: got %h want %h", got(), want()); end
      do_read();
   endtask

   task automatic test_break();
      align();
      bus.bit8 = 1'b1; bus.parity_en = 1'b0; bus.odd_n_even = 1'b0;
      bus.rx = 1'b0;
      repeat (1280) @(negedge clk);
      model_frame(8'h00, 1'b0, 1'b1, 1'b0);
      vec++; if (got() !== want()) begin fails++; $display("FAIL break_frame: got %h want %h", got(), want()); end
      do_read();
      repeat (1280) @(negedge clk);
      vec++; if (got() !== want()) begin fails++; $display("FAIL break_norestart: got %h want %h", got(), want()); end
      bus.rx = 1'b1;
      repeat (64) @(negedge clk);
      send_frame(8'h5A, 1, 0, 0, 0, 1);
      vec++; if (got() !== want()) begin fails++; $display("FAIL break_recover: got %h want %h", got(), want()); end
      do_read();
   endtask

   task automatic test_overflow();
      int lat;
      send_frame(8'h11, 1, 0, 0, 0, 1);
      send_frame(8'h22, 1, 0, 0, 0, 1);
      vec++; if (got() !== want()) begin fails++; $display("FAIL overflow: got %h want %h", got(), want()); end
      do_read();
      vec++; if (got() !== want()) begin fails++; $display("FAIL overflow_read: got %h want %h", got(), want()); end
      send_frame(8'h33, 1, 0, 0, 0, 1);
      lat = first_rdy;
      vec++; if (got() !== want()) begin fails++; $display("FAIL overflow_refill: got %h want %h", got(), want()); end
      send_frame(8'h22, 1, 0, 0, 0, 1, -1, lat - 1);
      vec++; if (got() !== want()) begin fails++; $display("FAIL load_and_read: got %h want %h", got(), want()); end
   endtask

   task automatic test_reset_mid();
      send_frame(8'hFF, 1, 0, 0, 0, 1, -1, -1, 5 * 64 + 20);
      vec++; if (got() !== 13'h001) begin fails++; $display("FAIL reset_mid: got %h want %h", got(), 13'h001); end
      send_frame(8'h81, 1, 0, 0, 0, 1);
      vec++; if (got() !== want()) begin fails++; $display("FAIL after_reset: got %h want %h", got(), want()); end
      do_read();
   endtask

   task automatic test_random();
      for (int k = 0; k < 12; k++) begin
         logic [7:0] d;
         logic b8, pen, odd, flip, stop;
         d = 8'($urandom);
         b8 = 1'($urandom);
         pen = 1'($urandom);
         odd = 1'($urandom);
         flip = pen && ($urandom_range(0, 3) == 0);
         stop = ($urandom_range(0, 7) != 0);
         send_frame(d, b8, pen, odd, flip, stop);
         vec++; if (got() !== want()) begin fails++; $display("FAIL random_%0d: got %h want %h", k, got(), want()); end
         if ($urandom_range(0, 1) == 1) begin
            do_read();
            vec++; if (got() !== want()) begin fails++; $display("FAIL random_read_%0d: got %h want %h", k, got(), want()); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_parity();
      test_glitch();
      test_framing();
      test_break();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
      $finish;
   end
endmodule
